// File: rtl/des_pkg.sv
// Shared definitions for the Triple-DES result path.
// Block width and default result FIFO depth.
package des_pkg;

    localparam int DES_BLOCK_W    = 64;
    localparam int DES_FIFO_DEPTH = 4;

    typedef logic [DES_BLOCK_W-1:0] des_block_t;

endpackage

// File: rtl/des_result_fifo_rise_detect.sv
// Rising-edge detector: registers a level and emits a one-cycle pulse.
// Reused for the DES done flag and the key-load strobe.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/des_result_fifo.sv
// FIFO buffering Triple-DES result blocks for the AHB-Lite read path.
// Define DES_FIFO_STATUS_EN to add sticky overflow/underflow outputs.
module des_result_fifo
    import des_pkg::*;
#(
    parameter int DEPTH = DES_FIFO_DEPTH,
    parameter int WIDTH = DES_BLOCK_W
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         done,
    input  logic [WIDTH-1:0]             outputData,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic                         full,
`ifdef DES_FIFO_STATUS_EN
    output logic                         overflow,
    output logic                         underflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop_ev;
    logic             wr_en;

    rise_detect u_done_edge (
        .clk   (HCLK),
        .rst_n (HRESET),
        .level (done),
        .pulse (push)
    );

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ev = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign wr_en  = push & (~full | pop_ev);

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ev) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(wr_en) - CW'(pop_ev);
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= outputData;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

`ifdef DES_FIFO_STATUS_EN
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !pop_ev) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_des_result_fifo.sv
// Self-checking bench for des_result_fifo against a queue-based model.
// Flag checks compile in only when DES_FIFO_STATUS_EN is defined.
module tb_des_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 64;

    logic             HCLK;
    logic             HRESET;
    logic             done;
    logic [WIDTH-1:0] outputData;
    logic             pop;
    logic             clear;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [2:0]       count;
`ifdef DES_FIFO_STATUS_EN
    logic             overflow;
    logic             underflow;
`endif

    des_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .done       (done),
        .outputData (outputData),
        .pop        (pop),
        .clear      (clear),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
`ifdef DES_FIFO_STATUS_EN
        .overflow   (overflow),
        .underflow  (underflow),
`endif
        .count      (count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic             m_prev;
    logic             m_ovf;
    logic             m_unf;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_head;
        exp_head = (q.size() == 0) ? '0 : q[0];
        chk({tag, ".count"}, WIDTH'(count), WIDTH'(q.size()));
        chk({tag, ".empty"}, WIDTH'(empty), WIDTH'(q.size() == 0));
        chk({tag, ".full"},  WIDTH'(full),  WIDTH'(q.size() == DEPTH));
        chk({tag, ".rd_data"}, rd_data, exp_head);
`ifdef DES_FIFO_STATUS_EN
        chk({tag, ".overflow"},  WIDTH'(overflow),  WIDTH'(m_ovf));
        chk({tag, ".underflow"}, WIDTH'(underflow), WIDTH'(m_unf));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Apply the rules for one clock edge using the inputs that were held.
    task automatic model_edge(input logic d, input logic [WIDTH-1:0] data,
                              input logic p, input logic c);
        bit push_evt;
        bit took_pop;
        push_evt = d && !m_prev;
        m_prev   = d;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && q.size() == 0) m_unf = 1'b1;
            took_pop = p && (q.size() > 0);
            if (push_evt && q.size() == DEPTH && !took_pop) m_ovf = 1'b1;
            if (took_pop) void'(q.pop_front());
            if (push_evt && q.size() < DEPTH) q.push_back(data);
        end
    endtask

    // Hold inputs across one rising edge, then check just after it.
    task automatic step(input string tag, input logic d,
                        input logic [WIDTH-1:0] data,
                        input logic p, input logic c);
        done       = d;
        outputData = data;
        pop        = p;
        clear      = c;
        @(posedge HCLK);
        #1;
        model_edge(d, data, p, c);
        check_all(tag);
    endtask

    task automatic push_blk(input string tag, input logic [WIDTH-1:0] data);
        step(tag, 1'b1, data, 1'b0, 1'b0);
        step(tag, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] a [4];
        logic [WIDTH-1:0] rnd;
        HRESET     = 1'b0;
        done       = 1'b0;
        outputData = '0;
        pop        = 1'b0;
        clear      = 1'b0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        check_all("reset");
        @(negedge HCLK);
        HRESET = 1'b1;

        step("idle", 1'b0, '0, 1'b0, 1'b0);
        step("pulse", 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        chk("pulse.const", rd_data, 64'h0123456789ABCDEF);
        step("pulse_lo", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++)
            step("hold", 1'b1, 64'hAAAA_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
        step("hold_lo", 1'b0, '0, 1'b0, 1'b0);
        step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("drain", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            a[i] = {$urandom, $urandom};
            push_blk("fill", a[i]);
        end
        chk("fill.full", WIDTH'(full), WIDTH'(1));
        push_blk("drop", 64'hDEAD_BEEF_DEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            chk("order", rd_data, a[i]);
            step("pop", 1'b0, '0, 1'b1, 1'b0);
        end
        chk("drained.empty", WIDTH'(empty), WIDTH'(1));

        for (int i = 0; i < 4; i++) push_blk("refill", {$urandom, $urandom});
        for (int i = 0; i < 7; i++) begin
            step("pp_full", 1'b1, 64'hB500_0000_0000_0000 + 64'(i), 1'b1, 1'b0);
            step("pp_lo", 1'b0, '0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step("pp_drain", 1'b0, '0, 1'b1, 1'b0);

        step("pp_empty", 1'b1, 64'hC1C1_C1C1_C1C1_C1C1, 1'b1, 1'b0);
        chk("pp_empty.const", rd_data, 64'hC1C1_C1C1_C1C1_C1C1);
        step("pp_empty_lo", 1'b0, '0, 1'b1, 1'b0);
        step("pop_empty", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) push_blk("three", {$urandom, $urandom});
        step("clear", 1'b1, 64'h5555, 1'b1, 1'b1);
        chk("clear.count", WIDTH'(count), WIDTH'(0));
        step("clear_lo", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom};
            step("rand", 1'($urandom_range(0, 1)), rnd,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end

        for (int i = 0; i < 3; i++) push_blk("burst", {$urandom, $urandom});
        done = 1'b1;
        outputData = 64'h1234;
        @(posedge HCLK);
        #3;
        HRESET = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        done = 1'b0;
        @(negedge HCLK);
        HRESET = 1'b1;
        step("post_rst_edge", 1'b1, 64'hFEED_FACE_0000_0001, 1'b0, 1'b0);
        step("post_rst_lo", 1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
